// File: rtl/addsub_rr_arbiter_if.sv
// Handshake/bus bundle between requesters and addsub_rr_arbiter.
// Ports (requester view, master modport):
//   req/op/a_bus/b_bus/rsp_ack driven by requesters; gnt/busy/rsp_* driven by the arbiter.
//   Operand slice for requester i sits at bits [W*i +: W] of a_bus and b_bus.
interface addsub_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op;
  logic [NREQ*W-1:0] a_bus;
  logic [NREQ*W-1:0] b_bus;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_s;
  logic              rsp_cout;
  logic              rsp_ack;

  modport master (
    output req, op, a_bus, b_bus, rsp_ack,
    input  gnt, busy, rsp_valid, rsp_id, rsp_s, rsp_cout
  );

  modport slave (
    input  req, op, a_bus, b_bus, rsp_ack,
    output gnt, busy, rsp_valid, rsp_id, rsp_s, rsp_cout
  );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin sharing of one 4-bit add/subtract unit among NREQ requesters.
// Latency: req seen in IDLE -> gnt next cycle -> rsp_valid the cycle after; one op per 3 cycles.
// Backpressure: rsp_* held in RESP until rsp_ack; no new grant while a result is outstanding.
// Ports: clk, rst (sync, active-high); bus (slave modport): req/op/a_bus/b_bus in, gnt one-hot
//   pulse, busy, rsp_valid/rsp_id/rsp_s/rsp_cout out, rsp_ack in.
// NREQ legal range 2..4 (2-bit ID); W must stay 4 to match add_subtract.

// add_subtract: 4-bit ripple adder/subtractor, S = A + (B ^ {4{Cin}}) + Cin.
// Latency: combinational.
// Backpressure: none.
module add_subtract (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [3:0] bx;
  logic [4:0] c;

  // Cin doubles as the mode bit: inverting B and injecting a carry gives two's-complement A-B.
  assign bx   = B ^ {4{Cin}};
  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end

  assign Cout = c[4];
endmodule

// addsub_rr_arbiter: arbitrates requesters onto the shared add_subtract and returns tagged results.
// Latency: 2 cycles req->rsp_valid (IDLE, EXEC), then RESP until acked.
// Backpressure: RESP holds rsp_* stable while rsp_ack=0; req is ignored outside IDLE.
module addsub_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input logic                clk,
  input logic                rst,
  addsub_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      win_q, win_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            op_q, op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_s_q, rsp_s_d;
  logic            rsp_cout_q, rsp_cout_d;

  logic [NREQ-1:0] req_sh;
  logic [1:0]      win_hi, win_lo, arb_win;
  logic            found_hi, found_lo;
  logic [W-1:0]    au_s;
  logic            au_cout;

  // Round-robin pick: the lowest requester above last wins; if none, wrap to the lowest overall.
  // Walking a shifted copy keeps every select constant.
  always_comb begin
    req_sh   = bus.req;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_sh[0]) begin
        if (!found_lo) begin
          win_lo   = 2'(i);
          found_lo = 1'b1;
        end
        if (!found_hi && (i > int'(last_q))) begin
          win_hi   = 2'(i);
          found_hi = 1'b1;
        end
      end
      req_sh = req_sh >> 1;
    end
    arb_win = found_hi ? win_hi : win_lo;
  end

  add_subtract u_au (
    .A    (a_q),
    .B    (b_q),
    .Cin  (op_q),
    .S    (au_s),
    .Cout (au_cout)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          // Operands are captured here, so requester changes after this edge are harmless.
          win_d   = arb_win;
          a_d     = W'(bus.a_bus >> (W * int'(arb_win)));
          b_d     = W'(bus.b_bus >> (W * int'(arb_win)));
          op_d    = 1'(bus.op >> arb_win);
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_s_d     = au_s;
        rsp_cout_d  = au_cout;
        rsp_valid_d = 1'b1;
        rsp_id_d    = win_q;
        last_d      = win_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ack) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 2'(NREQ - 1);
      win_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  // gnt is a decode of the EXEC state, so it is exactly one cycle wide and vanishes on reset.
  assign bus.gnt       = (state_q == EXEC) ? (NREQ'(1) << win_q) : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Bench for addsub_rr_arbiter: transaction-level model plus directed literal checks.
module tb_addsub_rr_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addsub_rr_arbiter_if #(.NREQ(NREQ), .W(4)) bus ();
  addsub_rr_arbiter #(.NREQ(NREQ), .W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference straight from the definition of modulo-16 add / subtract.
  function automatic int ref_s(input int a, input int b, input int op);
    return op != 0 ? ((a - b) & 15) : ((a + b) & 15);
  endfunction
  function automatic int ref_c(input int a, input int b, input int op);
    if (op != 0) return (a >= b) ? 1 : 0;
    return (a + b > 15) ? 1 : 0;
  endfunction

  // ---------------- behavioural model ----------------
  // m_phase counts position within one operation: 0 waiting, 1 granted, 2 result outstanding.
  int m_phase, m_last, m_win, m_id, m_s, m_cout, p_s, p_cout, m_idx, m_a, m_b, m_o;
  bit m_valid = 1'b0, m_init = 1'b0, m_found;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_phase = 0; m_last = NREQ - 1; m_valid = 1'b0;
      m_id = 0; m_s = 0; m_cout = 0; m_win = 0;
    end else if (m_init) begin
      case (m_phase)
        0: if (bus.req != '0) begin
          m_found = 1'b0;
          for (int k = 1; k <= NREQ; k++) begin
            m_idx = (m_last + k) % NREQ;
            if (!m_found && (((bus.req >> m_idx) & 4'd1) != 0)) begin
              m_win = m_idx; m_found = 1'b1;
            end
          end
          m_a = int'((bus.a_bus >> (4 * m_win)) & 16'hF);
          m_b = int'((bus.b_bus >> (4 * m_win)) & 16'hF);
          m_o = int'((bus.op >> m_win) & 4'd1);
          p_s = ref_s(m_a, m_b, m_o);
          p_cout = ref_c(m_a, m_b, m_o);
          m_phase = 1;
        end
        1: begin
          m_valid = 1'b1; m_id = m_win; m_s = p_s; m_cout = p_cout;
          m_last = m_win; m_phase = 2;
        end
        default: if (bus.rsp_ack) begin
          m_valid = 1'b0; m_phase = 0;
        end
      endcase
    end
  end

  function automatic logic [3:0] model_gnt();
    return (m_phase == 1) ? 4'(1 << m_win) : 4'b0;
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      check("model_ctrl", 32'({bus.gnt, bus.busy, bus.rsp_valid}),
            32'({model_gnt(), (m_phase != 0), m_valid}));
      if (m_valid)
        check("model_rsp", 32'({bus.rsp_id, bus.rsp_s, bus.rsp_cout}),
              32'({2'(m_id), 4'(m_s), 1'(m_cout)}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_opnd(input int i, input int a, input int b, input int op);
    bus.a_bus = (bus.a_bus & ~(16'hF << (4 * i))) | (16'(a & 15) << (4 * i));
    bus.b_bus = (bus.b_bus & ~(16'hF << (4 * i))) | (16'(b & 15) << (4 * i));
    bus.op    = (bus.op & ~(4'd1 << i)) | (4'(op & 1) << i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full operation from IDLE: request, check grant, check result, ack.
  task automatic op_cycle(input string nm, input logic [3:0] r, input bit hold,
                          input logic [3:0] eg, input logic [1:0] eid,
                          input logic [3:0] es, input logic ec);
    bus.req = r;
    @(negedge clk);
    check({nm, "_gnt"}, 32'({bus.gnt, bus.busy}), 32'({eg, 1'b1}));
    if (!hold) bus.req = '0;
    @(negedge clk);
    check({nm, "_rsp"}, 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout}),
          32'({1'b1, eid, es, ec}));
    bus.rsp_ack = 1'b1;
    @(negedge clk);
    bus.rsp_ack = 1'b0;
  endtask

  int gorder [5] = '{0, 1, 2, 3, 0};
  logic [3:0] eg_r;

  initial begin
    rst = 1'b1; bus.req = '0; bus.op = '0; bus.a_bus = '0; bus.b_bus = '0; bus.rsp_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({bus.gnt, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_s,
          bus.rsp_cout}), 32'd0);
    rst = 1'b0;

    // T1 add
    set_opnd(0, 1, 5, 0);
    op_cycle("t1_add", 4'b0001, 1'b0, 4'b0001, 2'd0, 4'h6, 1'b0);
    check("t1_idle", 32'({bus.busy, bus.rsp_valid}), 32'd0);

    // T2 subtract
    set_opnd(1, 5, 5, 1);
    op_cycle("t2_sub_eq", 4'b0010, 1'b0, 4'b0010, 2'd1, 4'h0, 1'b1);
    set_opnd(1, 3, 5, 1);
    op_cycle("t2_sub_lt", 4'b0010, 1'b0, 4'b0010, 2'd1, 4'hE, 1'b0);

    // T3 round robin from reset; requester i computes (i+1)+2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_opnd(i, i + 1, 2, 0);
    foreach (gorder[k])
      op_cycle("t3_rr", 4'b1111, 1'b1, 4'(1 << gorder[k]), 2'(gorder[k]),
               4'(gorder[k] + 3), 1'b0);
    op_cycle("t3_0101a", 4'b0101, 1'b0, 4'b0100, 2'd2, 4'h5, 1'b0);
    op_cycle("t3_0101b", 4'b0101, 1'b0, 4'b0001, 2'd0, 4'h3, 1'b0);

    // T4 backpressure: last=0, so requester 1 wins
    bus.req = 4'b1111;
    @(negedge clk);
    check("t4_gnt", 32'(bus.gnt), 32'(4'b0010));
    repeat (10) begin
      @(negedge clk);
      check("t4_hold", 32'({bus.gnt, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_s,
            bus.rsp_cout}), 32'({4'b0000, 1'b1, 1'b1, 2'd1, 4'h4, 1'b0}));
    end
    bus.rsp_ack = 1'b1;
    @(negedge clk);
    bus.rsp_ack = 1'b0;
    check("t4_ack_idle", 32'({bus.gnt, bus.busy, bus.rsp_valid}), 32'd0);
    @(negedge clk);
    check("t4_regnt", 32'(bus.gnt), 32'(4'b0100));
    bus.req = '0;
    @(negedge clk);
    check("t4_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_s}), 32'({1'b1, 2'd2, 4'h5}));
    bus.rsp_ack = 1'b1;
    @(negedge clk);
    bus.rsp_ack = 1'b0;

    // T5 reset in EXEC: last=2, req=1010 -> 3 wins, then reset restarts priority at 0
    bus.req = 4'b1010;
    @(negedge clk);
    check("t5_gnt", 32'(bus.gnt), 32'(4'b1000));
    rst = 1'b1;
    @(negedge clk);
    check("t5_reset", 32'({bus.gnt, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_s,
          bus.rsp_cout}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_regnt", 32'(bus.gnt), 32'(4'b0010));
    bus.req = '0;
    @(negedge clk);
    check("t5_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_s}), 32'({1'b1, 2'd1, 4'h4}));
    bus.rsp_ack = 1'b1;
    @(negedge clk);
    bus.rsp_ack = 1'b0;

    // T6 exhaustive through requester 3
    for (int o = 0; o < 2; o++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          set_opnd(3, a, b, o);
          op_cycle("t6", 4'b1000, 1'b0, 4'b1000, 2'd3, 4'(ref_s(a, b, o)), 1'(ref_c(a, b, o)));
        end

    // Random traffic: requesters hold until granted, operands scrambled after grant,
    // random acks and occasional resets; the model compare process checks every cycle.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      eg_r = model_gnt();
      for (int i = 0; i < NREQ; i++) begin
        if (((eg_r >> i) & 4'd1) != 0) begin
          if ($urandom_range(0, 3) == 0) bus.req = bus.req | (4'd1 << i);
          else                           bus.req = bus.req & ~(4'd1 << i);
          set_opnd(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)));
        end else if (((bus.req >> i) & 4'd1) == 0 && $urandom_range(0, 2) == 0) begin
          bus.req = bus.req | (4'd1 << i);
          set_opnd(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)));
        end
      end
      bus.rsp_ack = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    rst = 1'b0; bus.req = '0; bus.rsp_ack = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
